// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster timing constants and the shared coordinate type.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525

    // Sync windows are [START, END): hs low for 656..751, vs low for 490..491.
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div: divides clk by CLK_DIV into a registered one-clock pixel_en pulse.
// First pulse is visible in clock CLK_DIV after reset release, then every CLK_DIV clocks.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pixel_en_q, pixel_en_d;

    // Next count wraps at CLK_DIV-1; the pulse is flagged on the wrapping clock.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        pixel_en_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            pixel_en_d = 1'b1;
        end
    end

    // Divider registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            pixel_en_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pixel_en_q <= pixel_en_d;
        end
    end

    assign pixel_en = pixel_en_q;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster generator (DrawX/DrawY, hs/vs, active_nblank, line/frame pulses).
// Optional macro VGA_SYNC_DELAY_EN: delays hs/vs/active_nblank by SYNC_DELAY pixel ticks
// to line them up with registered render latency; coordinates and pulses stay undelayed.
module vga_scan_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int SYNC_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   pixel_en,
    output vga_timing_pkg::coord_t DrawX,
    output vga_timing_pkg::coord_t DrawY,
    output logic                   hs,
    output logic                   vs,
    output logic                   active_nblank,
    output logic                   line_start,
    output logic                   frame_start
);

    typedef vga_timing_pkg::coord_t coord_t;

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t X_HS_LO  = coord_t'(HS_START);
    localparam coord_t X_HS_HI  = coord_t'(HS_END);
    localparam coord_t Y_VS_LO  = coord_t'(VS_START);
    localparam coord_t Y_VS_HI  = coord_t'(VS_END);
    localparam coord_t X_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS    = coord_t'(V_VISIBLE);

    logic   tick;
    coord_t x_q, x_d, y_q, y_d;
    logic   hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic   line_q, line_d, frame_q, frame_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .pixel_en (tick)
    );

    // Next raster position plus sync/blank decode taken from that next position.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d    = '0;
                line_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    frame_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        hs_d  = !((x_d >= X_HS_LO) && (x_d < X_HS_HI));
        vs_d  = !((y_d >= Y_VS_LO) && (y_d < Y_VS_HI));
        act_d = (x_d < X_VIS) && (y_d < Y_VIS);
    end

    // Counters and decode advance together on the pixel tick; pulses last one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            act_q   <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            frame_q <= frame_d;
            if (tick) begin
                x_q   <= x_d;
                y_q   <= y_d;
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                act_q <= act_d;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [SYNC_DELAY-1:0] hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d, act_sr_q, act_sr_d;

    // Shift chain input is the aligned decode; stage i holds the decode from i+1 ticks ago.
    always_comb begin
        hs_sr_d     = hs_sr_q;
        vs_sr_d     = vs_sr_q;
        act_sr_d    = act_sr_q;
        hs_sr_d[0]  = hs_q;
        vs_sr_d[0]  = vs_q;
        act_sr_d[0] = act_q;
        for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_sr_d[i]  = hs_sr_q[i-1];
            vs_sr_d[i]  = vs_sr_q[i-1];
            act_sr_d[i] = act_sr_q[i-1];
        end
    end

    // Delay chain advances only on the pixel tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_sr_q  <= '1;
            vs_sr_q  <= '1;
            act_sr_q <= '0;
        end else if (tick) begin
            hs_sr_q  <= hs_sr_d;
            vs_sr_q  <= vs_sr_d;
            act_sr_q <= act_sr_d;
        end
    end

    assign hs            = hs_sr_q[SYNC_DELAY-1];
    assign vs            = vs_sr_q[SYNC_DELAY-1];
    assign active_nblank = act_sr_q[SYNC_DELAY-1];
`else
    assign hs            = hs_q;
    assign vs            = vs_q;
    assign active_nblank = act_q;
`endif

    assign pixel_en    = tick;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule
